sprite_pixel_pipeline: RTL and testbench

- Parametrised successor to the single-sprite VGA colour path.
- Sits between `SVGA_sync` and the `VGA_R/G/B` pins. Per pixel it tests up to `ELEMENTS` positioned sprites and picks the highest-priority hit. It reads that sprite's texel from the sprite memory and emits registered RGB.
- `hsync`/`vsync` are delayed to match the colour path.
- Sprite attributes are double-buffered and committed once per frame, so moves never tear mid-frame.

---
 rtl/sprite_pkg.sv | 16 +
 rtl/sprite_hit_unit.sv | 34 +++
 rtl/sprite_pixel_pipeline.sv | 204 ++++++++++++++++++++
 tb/tb_sprite_pixel_pipeline.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and widths for the sprite pixel pipeline.
package sprite_pkg;

    localparam int PIPE_LAT   = 3;
    localparam int X_W        = 11;
    localparam int Y_W        = 10;
    localparam int ATTR_IMG_W = 3;

    typedef struct packed {
        logic [X_W-1:0]        x;
        logic [Y_W-1:0]        y;
        logic [ATTR_IMG_W-1:0] img;
        logic                  on;
    } sprite_attr_t;

endpackage

// File: rtl/sprite_hit_unit.sv
// Per-slot hit test and texel offset for one sprite.
module sprite_hit_unit
    import sprite_pkg::*;
#(
    parameter int SPRITE_SIZE = 20,
    parameter int ADDR_W      = 10
) (
    input  logic [X_W-1:0]    pixel_x,
    input  logic [Y_W-1:0]    pixel_y,
    input  sprite_attr_t      attr,
    output logic              hit,
    output logic [ADDR_W-1:0] offset
);

    logic [X_W:0] px_w, x0_w, x1_w, dx_w;
    logic [Y_W:0] py_w, y0_w, y1_w, dy_w;

    // One extra bit on each axis so x+SIZE never wraps; sprites clip.
    always_comb begin
        px_w   = {1'b0, pixel_x};
        x0_w   = {1'b0, attr.x};
        x1_w   = x0_w + (X_W+1)'(SPRITE_SIZE);
        py_w   = {1'b0, pixel_y};
        y0_w   = {1'b0, attr.y};
        y1_w   = y0_w + (Y_W+1)'(SPRITE_SIZE);
        dx_w   = px_w - x0_w;
        dy_w   = py_w - y0_w;
        hit    = attr.on
               && (px_w >= x0_w) && (px_w < x1_w)
               && (py_w >= y0_w) && (py_w < y1_w);
        offset = ADDR_W'(32'(dy_w) * SPRITE_SIZE + 32'(dx_w));
    end

endmodule

// File: rtl/sprite_pixel_pipeline.sv
// Multi-sprite VGA colour path: hit test, priority, texel fetch, RGB out.
// Define SPRITE_TRANSPARENCY_EN to treat all-zero texels as background.
module sprite_pixel_pipeline
    import sprite_pkg::*;
#(
    parameter int ELEMENTS    = 4,
    parameter int SPRITE_SIZE = 20,
    parameter int ADDR_W      = 10,
    parameter int IMG_W       = 3,
    parameter int MEM_CH_BITS = 4,
    parameter int OUT_CH_BITS = 3,
    parameter int V_ACTIVE    = 600
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          video_enable,
    input  logic [10:0]                   pixel_x,
    input  logic [9:0]                    pixel_y,
    input  logic                          hsync_in,
    input  logic                          vsync_in,
    input  logic                          reg_wr,
    input  logic [$clog2(ELEMENTS)-1:0]   reg_index,
    input  logic [10:0]                   reg_x,
    input  logic [9:0]                    reg_y,
    input  logic [IMG_W-1:0]              reg_img,
    input  logic                          reg_on,
    input  logic [3*OUT_CH_BITS-1:0]      bg_colour,
    output logic                          mem_rd_en,
    output logic [IMG_W-1:0]              mem_img,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic [3*MEM_CH_BITS-1:0]      mem_data,
    output logic [OUT_CH_BITS-1:0]        vga_r,
    output logic [OUT_CH_BITS-1:0]        vga_g,
    output logic [OUT_CH_BITS-1:0]        vga_b,
    output logic                          hsync,
    output logic                          vsync
);

    localparam int MW = 3 * MEM_CH_BITS;
    localparam int CW = 3 * OUT_CH_BITS;
`ifdef SPRITE_TRANSPARENCY_EN
    localparam bit TRANSP = 1'b1;
`else
    localparam bit TRANSP = 1'b0;
`endif

    sprite_attr_t shadow_q [ELEMENTS];
    sprite_attr_t shadow_d [ELEMENTS];
    sprite_attr_t active_q [ELEMENTS];
    sprite_attr_t active_d [ELEMENTS];
    sprite_attr_t wr_attr;
    logic         commit;

    logic [ELEMENTS-1:0]   hit_c;
    logic [ADDR_W-1:0]     off_c [ELEMENTS];

    logic [ELEMENTS-1:0]   s1_hit_q, s1_hit_d;
    logic [ADDR_W-1:0]     s1_off_q [ELEMENTS];
    logic [ADDR_W-1:0]     s1_off_d [ELEMENTS];
    logic [ATTR_IMG_W-1:0] s1_img_q [ELEMENTS];
    logic [ATTR_IMG_W-1:0] s1_img_d [ELEMENTS];
    logic                  s1_act_q, s1_act_d;

    logic                  mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [IMG_W-1:0]      mem_img_q, mem_img_d;
    logic                  s2_act_q, s2_act_d;
    logic                  sel_found;
    logic [ADDR_W-1:0]     sel_addr;
    logic [ATTR_IMG_W-1:0] sel_img;

    logic                  mw_hit_q, mw_hit_d;
    logic                  mw_act_q, mw_act_d;
    logic                  mem_zero, draw;
    logic [CW-1:0]         rgb_q, rgb_d;
    logic [PIPE_LAT:0]     hs_pipe_q, hs_pipe_d;
    logic [PIPE_LAT:0]     vs_pipe_q, vs_pipe_d;

    for (genvar i = 0; i < ELEMENTS; i++) begin : g_hit
        sprite_hit_unit #(
            .SPRITE_SIZE (SPRITE_SIZE),
            .ADDR_W      (ADDR_W)
        ) u_hit (
            .pixel_x (pixel_x),
            .pixel_y (pixel_y),
            .attr    (active_q[i]),
            .hit     (hit_c[i]),
            .offset  (off_c[i])
        );
    end

    // Shadow write lands before the commit copy, giving write-through.
    always_comb begin
        wr_attr  = '{x: reg_x, y: reg_y,
                     img: ATTR_IMG_W'(reg_img), on: reg_on};
        commit   = (pixel_y == Y_W'(V_ACTIVE)) && (pixel_x == '0);
        shadow_d = shadow_q;
        if (reg_wr && (int'(reg_index) < ELEMENTS)) begin
            shadow_d[reg_index] = wr_attr;
        end
        active_d = active_q;
        if (commit) begin
            active_d = shadow_d;
        end
    end

    always_comb begin
        s1_hit_d = hit_c;
        s1_act_d = video_enable;
        for (int i = 0; i < ELEMENTS; i++) begin
            s1_off_d[i] = off_c[i];
            s1_img_d[i] = active_q[i].img;
        end
    end

    // Descending scan: the lowest hitting index is assigned last and wins.
    always_comb begin
        sel_found = 1'b0;
        sel_addr  = '0;
        sel_img   = '0;
        for (int i = ELEMENTS - 1; i >= 0; i--) begin
            if (s1_hit_q[i]) begin
                sel_found = 1'b1;
                sel_addr  = s1_off_q[i];
                sel_img   = s1_img_q[i];
            end
        end
        mem_rd_en_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_img_d   = mem_img_q;
        if (s1_act_q && sel_found) begin
            mem_rd_en_d = 1'b1;
            mem_addr_d  = sel_addr;
            mem_img_d   = IMG_W'(sel_img);
        end
        s2_act_d = s1_act_q;
    end

    // Flags wait one cycle for the memory, then meet mem_data here.
    always_comb begin
        mw_hit_d = mem_rd_en_q;
        mw_act_d = s2_act_q;
        mem_zero = ~|mem_data;
        draw     = mw_hit_q && !(TRANSP && mem_zero);
        rgb_d    = '0;
        if (mw_act_q) begin
            rgb_d = draw
                ? {mem_data[MW-1 -: OUT_CH_BITS],
                   mem_data[2*MEM_CH_BITS-1 -: OUT_CH_BITS],
                   mem_data[MEM_CH_BITS-1 -: OUT_CH_BITS]}
                : bg_colour;
        end
        hs_pipe_d = {hs_pipe_q[PIPE_LAT-1:0], hsync_in};
        vs_pipe_d = {vs_pipe_q[PIPE_LAT-1:0], vsync_in};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ELEMENTS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
                s1_off_q[i] <= '0;
                s1_img_q[i] <= '0;
            end
            s1_hit_q    <= '0;
            s1_act_q    <= 1'b0;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_img_q   <= '0;
            s2_act_q    <= 1'b0;
            mw_hit_q    <= 1'b0;
            mw_act_q    <= 1'b0;
            rgb_q       <= '0;
            hs_pipe_q   <= '0;
            vs_pipe_q   <= '0;
        end else begin
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            s1_off_q    <= s1_off_d;
            s1_img_q    <= s1_img_d;
            s1_hit_q    <= s1_hit_d;
            s1_act_q    <= s1_act_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_addr_q  <= mem_addr_d;
            mem_img_q   <= mem_img_d;
            s2_act_q    <= s2_act_d;
            mw_hit_q    <= mw_hit_d;
            mw_act_q    <= mw_act_d;
            rgb_q       <= rgb_d;
            hs_pipe_q   <= hs_pipe_d;
            vs_pipe_q   <= vs_pipe_d;
        end
    end

    assign mem_rd_en = mem_rd_en_q;
    assign mem_addr  = mem_addr_q;
    assign mem_img   = mem_img_q;
    assign vga_r     = rgb_q[CW-1 -: OUT_CH_BITS];
    assign vga_g     = rgb_q[2*OUT_CH_BITS-1 -: OUT_CH_BITS];
    assign vga_b     = rgb_q[OUT_CH_BITS-1 -: OUT_CH_BITS];
    assign hsync     = hs_pipe_q[PIPE_LAT];
    assign vsync     = vs_pipe_q[PIPE_LAT];

endmodule

// File: tb/tb_sprite_pixel_pipeline.sv
// Directed plus randomized bench for sprite_pixel_pipeline.
module tb_sprite_pixel_pipeline;

    localparam int EL = 4;
    localparam int SS = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        video_enable = 1'b0;
    logic [10:0] pixel_x = '0;
    logic [9:0]  pixel_y = '0;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic        reg_wr = 1'b0;
    logic [1:0]  reg_index = '0;
    logic [10:0] reg_x = '0;
    logic [9:0]  reg_y = '0;
    logic [2:0]  reg_img = '0;
    logic        reg_on = 1'b0;
    logic [8:0]  bg_colour = 9'o123;
    logic        mem_rd_en;
    logic [2:0]  mem_img;
    logic [9:0]  mem_addr;
    logic [11:0] mem_data = '0;
    logic [2:0]  vga_r, vga_g, vga_b;
    logic        hsync, vsync;

    sprite_pixel_pipeline dut (
        .clk          (clk),
        .reset        (reset),
        .video_enable (video_enable),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .hsync_in     (hsync_in),
        .vsync_in     (vsync_in),
        .reg_wr       (reg_wr),
        .reg_index    (reg_index),
        .reg_x        (reg_x),
        .reg_y        (reg_y),
        .reg_img      (reg_img),
        .reg_on       (reg_on),
        .bg_colour    (bg_colour),
        .mem_rd_en    (mem_rd_en),
        .mem_img      (mem_img),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .vga_r        (vga_r),
        .vga_g        (vga_g),
        .vga_b        (vga_b),
        .hsync        (hsync),
        .vsync        (vsync)
    );

    always #10 clk = ~clk;

`ifdef SPRITE_TRANSPARENCY_EN
    bit transp = 1'b1;
`else
    bit transp = 1'b0;
`endif

    int sh_x[EL], sh_y[EL], sh_img[EL];
    bit sh_on[EL];
    int ac_x[EL], ac_y[EL], ac_img[EL];
    bit ac_on[EL];
    int q_rgb[$], q_addr[$], q_img[$];
    bit q_hs[$], q_vs[$], q_rd[$];
    int last_addr, last_img;
    int n_cmp = 0;
    int n_bad = 0;

    // Texture content; address 5 of every image is all-zero.
    function automatic int texel(int img, int addr);
        int v;
        if (addr == 5) return 0;
        v = (addr * 37 + img * 111 + 1) % 4096;
        if (v == 0) v = 1;
        return v;
    endfunction

    function automatic int to_rgb(int d);
        return (((d >> 9) & 7) << 6) | (((d >> 5) & 7) << 3) | ((d >> 1) & 7);
    endfunction

    always @(posedge clk) begin
        if (mem_rd_en) mem_data <= 12'(texel(int'(mem_img), int'(mem_addr)));
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        reg_wr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rgb", 32'({vga_r, vga_g, vga_b}), 0);
        chk("rst_hsync", 32'(hsync), 0);
        chk("rst_vsync", 32'(vsync), 0);
        chk("rst_rd_en", 32'(mem_rd_en), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_img", 32'(mem_img), 0);
        for (int i = 0; i < EL; i++) begin
            sh_x[i] = 0; sh_y[i] = 0; sh_img[i] = 0; sh_on[i] = 0;
            ac_x[i] = 0; ac_y[i] = 0; ac_img[i] = 0; ac_on[i] = 0;
        end
        q_rgb.delete(); q_hs.delete(); q_vs.delete();
        q_rd.delete(); q_addr.delete(); q_img.delete();
        repeat (3) begin
            q_rgb.push_back(0); q_hs.push_back(0); q_vs.push_back(0);
        end
        q_rd.push_back(0); q_addr.push_back(0); q_img.push_back(0);
        last_addr = 0;
        last_img = 0;
        reset = 1'b0;
    endtask

    task automatic wr(input int idx, input int x, input int y,
                      input int img, input bit on);
        reg_wr = 1'b1;
        reg_index = 2'(idx);
        reg_x = 11'(x);
        reg_y = 10'(y);
        reg_img = 3'(img);
        reg_on = on;
    endtask

    task automatic pix(input bit ve, input int px, input int py);
        int win, addr, rgb, d, rd_e, a_e, i_e;
        win = -1;
        addr = 0;
        video_enable = ve;
        pixel_x = 11'(px);
        pixel_y = 10'(py);
        hsync_in = 1'($urandom);
        vsync_in = 1'($urandom);
        for (int i = 0; i < EL; i++) begin
            if (win < 0 && ac_on[i] && px >= ac_x[i] && px < ac_x[i] + SS
                && py >= ac_y[i] && py < ac_y[i] + SS) begin
                win = i;
                addr = (py - ac_y[i]) * SS + (px - ac_x[i]);
            end
        end
        if (!ve) rgb = 0;
        else if (win < 0) rgb = int'(bg_colour);
        else begin
            d = texel(ac_img[win], addr);
            rgb = (transp && d == 0) ? int'(bg_colour) : to_rgb(d);
        end
        q_rgb.push_back(rgb);
        q_hs.push_back(hsync_in);
        q_vs.push_back(vsync_in);
        q_rd.push_back(ve && win >= 0);
        q_addr.push_back(addr);
        q_img.push_back(win >= 0 ? ac_img[win] : 0);
        @(posedge clk);
        if (reg_wr) begin
            sh_x[reg_index] = int'(reg_x);
            sh_y[reg_index] = int'(reg_y);
            sh_img[reg_index] = int'(reg_img);
            sh_on[reg_index] = reg_on;
        end
        if (px == 0 && py == 600) begin
            for (int i = 0; i < EL; i++) begin
                ac_x[i] = sh_x[i]; ac_y[i] = sh_y[i];
                ac_img[i] = sh_img[i]; ac_on[i] = sh_on[i];
            end
        end
        #1;
        reg_wr = 1'b0;
        rd_e = int'(q_rd.pop_front());
        a_e = q_addr.pop_front();
        i_e = q_img.pop_front();
        if (rd_e != 0) begin
            last_addr = a_e;
            last_img = i_e;
        end
        chk("rd_en", 32'(mem_rd_en), 32'(rd_e));
        chk("mem_addr", 32'(mem_addr), 32'(last_addr));
        chk("mem_img", 32'(mem_img), 32'(last_img));
        chk("rgb", 32'({vga_r, vga_g, vga_b}), 32'(q_rgb.pop_front()));
        chk("hsync", 32'(hsync), 32'(q_hs.pop_front()));
        chk("vsync", 32'(vsync), 32'(q_vs.pop_front()));
    endtask

    task automatic flush();
        repeat (4) pix(1'b0, 10, 620);
    endtask

    initial begin
        int px, py, s;
        do_reset();

        // Idle frame: background inside, black outside, no reads.
        for (int i = 0; i < 200; i++) begin
            py = $urandom_range(0, 627);
            px = $urandom_range(0, 1055);
            pix(py < 600 && px < 800 && $urandom_range(0, 3) != 0, px, py);
        end
        pix(1'b1, 400, 300);
        pix(1'b0, 0, 0);
        pix(1'b0, 0, 0);
        pix(1'b0, 0, 0);
        chk("idle_bg", 32'({vga_r, vga_g, vga_b}), 32'(9'o123));
        pix(1'b0, 0, 600);

        // Single sprite corners and just-outside pixels.
        wr(0, 100, 50, 5, 1'b1);
        pix(1'b0, 10, 610);
        pix(1'b0, 0, 600);
        pix(1'b1, 100, 50);
        pix(1'b1, 119, 69);
        chk("addr_first", 32'(mem_addr), 0);
        pix(1'b1, 120, 50);
        chk("addr_last", 32'(mem_addr), 399);
        pix(1'b1, 105, 50);
        chk("miss_right", 32'(mem_rd_en), 0);
        pix(1'b1, 100, 70);
        pix(1'b1, 99, 50);
        pix(1'b1, 110, 60);
        flush();

        // Overlap; slot 2 written on the commit cycle itself.
        wr(0, 200, 200, 5, 1'b1);
        pix(1'b0, 10, 610);
        wr(2, 210, 210, 6, 1'b1);
        pix(1'b0, 0, 600);
        pix(1'b1, 215, 215);
        pix(1'b1, 225, 225);
        chk("overlap_img", 32'(mem_img), 5);
        pix(1'b0, 0, 0);
        chk("low_prio_img", 32'(mem_img), 6);
        for (int i = 0; i < 150; i++) begin
            pix(1'b1, $urandom_range(195, 235), $urandom_range(195, 235));
        end
        flush();

        // Mid-frame write stays hidden until the next commit.
        wr(1, 300, 300, 3, 1'b1);
        pix(1'b1, 305, 305);
        pix(1'b1, 306, 305);
        chk("midframe_hidden", 32'(mem_rd_en), 0);
        for (int i = 0; i < 40; i++) begin
            pix(1'b1, $urandom_range(298, 322), $urandom_range(298, 322));
        end
        wr(3, 400, 400, 7, 1'b1);
        pix(1'b0, 0, 600);
        pix(1'b1, 305, 305);
        pix(1'b1, 405, 405);
        chk("after_commit", 32'(mem_img), 3);
        pix(1'b0, 0, 0);
        chk("commit_write", 32'(mem_img), 7);
        flush();

        // Right-edge clip: no wrap to the left columns.
        wr(1, 790, 10, 2, 1'b1);
        pix(1'b0, 0, 600);
        for (int x = 780; x < 800; x++) pix(1'b1, x, 10);
        for (int x = 0; x < 12; x++) pix(1'b1, x, 10);
        pix(1'b1, 799, 29);
        pix(1'b1, 799, 30);
        pix(1'b1, 5, 10);
        pix(1'b0, 0, 0);
        chk("no_wrap", 32'(mem_rd_en), 0);
        pix(1'b1, 799, 10);
        pix(1'b0, 0, 0);
        chk("right_col", 32'(mem_rd_en), 1);
        flush();

        // Reset in the middle of a frame.
        pix(1'b1, 215, 215);
        pix(1'b1, 216, 215);
        do_reset();
        for (int i = 0; i < 10; i++) pix(1'b1, 215, 215);

        // Random writes, commits and pixels biased around sprites.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                wr($urandom_range(0, 3), $urandom_range(0, 820),
                   $urandom_range(0, 620), $urandom_range(0, 7),
                   $urandom_range(0, 4) != 0);
            end
            if ($urandom_range(0, 39) == 0) begin
                pix(1'b0, 0, 600);
            end else begin
                s = $urandom_range(0, 3);
                if ($urandom_range(0, 3) != 0) begin
                    px = ac_x[s] + $urandom_range(0, 29) - 5;
                    py = ac_y[s] + $urandom_range(0, 29) - 5;
                    if (px < 0) px = 0;
                    if (py < 0) py = 0;
                end else begin
                    px = $urandom_range(0, 850);
                    py = $urandom_range(0, 630);
                end
                pix(py < 600 && px < 800 && $urandom_range(0, 7) != 0,
                    px, py);
            end
        end
        flush();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
